// File: rtl/dac_arb_pkg.sv
// Shared types and constants for the DAC write arbiter.
// Optional feature macro: DAC_LDAC_EN (adds the LDAC latch state).
package dac_arb_pkg;

  localparam int FRAME_W = 16;
  localparam int DATA_W  = 12;
  localparam int CFG_W   = 4;
  localparam int NBIT_W  = $clog2(FRAME_W);

  // Header bit positions inside the 4-bit cfg field
  localparam int CFG_AB     = 3;
  localparam int CFG_BUF    = 2;
  localparam int CFG_GA_N   = 1;
  localparam int CFG_SHDN_N = 0;

`ifdef DAC_LDAC_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_LDAC  = 2'd3
  } tx_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } tx_state_t;
`endif

  function automatic logic [FRAME_W-1:0] mk_frame(
    input logic [CFG_W-1:0]  cfg,
    input logic [DATA_W-1:0] data
  );
    return {cfg, data};
  endfunction

endpackage

// File: rtl/dac_write_arbiter_spi_frame_tx.sv
// spi_frame_tx: serializes one 16-bit DAC frame (cs_n/sck/mosi).
// Ports: clk, rst, i_start, i_frame in; o_done, o_idle, o_cs_n,
// o_sck, o_mosi out (+ o_ldac_n when DAC_LDAC_EN is defined).
module spi_frame_tx
  import dac_arb_pkg::*;
#(
  parameter int SCK_DIV = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [FRAME_W-1:0] i_frame,
  output logic               o_done,
  output logic               o_idle,
`ifdef DAC_LDAC_EN
  output logic               o_ldac_n,
`endif
  output logic               o_cs_n,
  output logic               o_sck,
  output logic               o_mosi
);

  localparam int DW = (SCK_DIV > 2) ? $clog2(SCK_DIV) : 1;

  tx_state_t          r_state;
  logic [DW-1:0]      r_div;
  logic [FRAME_W-1:0] r_sh;
  logic [NBIT_W-1:0]  r_nbit;
  logic               r_ph;
  logic               r_done;
  logic               r_cs_n;
  logic               r_sck;
  logic               r_mosi;
`ifdef DAC_LDAC_EN
  logic               r_ldac_n;
`endif

  logic w_tick;
  assign w_tick = (r_div == DW'(SCK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_div    <= '0;
      r_sh     <= '0;
      r_nbit   <= '0;
      r_ph     <= 1'b0;
      r_done   <= 1'b0;
      r_cs_n   <= 1'b1;
      r_sck    <= 1'b0;
      r_mosi   <= 1'b0;
`ifdef DAC_LDAC_EN
      r_ldac_n <= 1'b1;
`endif
    end else begin
      r_done <= 1'b0;
      // Divider runs only while a frame is in flight
      if (r_state == ST_IDLE || w_tick) r_div <= '0;
      else                              r_div <= r_div + 1'b1;
      unique case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_sh    <= i_frame;
            r_mosi  <= i_frame[FRAME_W-1];
            r_cs_n  <= 1'b0;
            r_sck   <= 1'b0;
            r_nbit  <= '0;
            r_ph    <= 1'b0;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_tick) begin
            r_sck <= ~r_sck;
            // Falling edge: advance to the next bit
            if (r_sck) begin
              r_sh   <= r_sh << 1;
              r_nbit <= r_nbit + 1'b1;
              if (r_nbit == NBIT_W'(FRAME_W - 1)) begin
                r_mosi  <= 1'b0;
                r_state <= ST_GAP;
              end else begin
                r_mosi <= r_sh[FRAME_W-2];
              end
            end
          end
        end
        ST_GAP: begin
          if (w_tick) begin
            // First gap tick raises cs_n, second ends the gap
            if (!r_ph) begin
              r_cs_n <= 1'b1;
              r_ph   <= 1'b1;
            end else begin
              r_ph <= 1'b0;
`ifdef DAC_LDAC_EN
              r_ldac_n <= 1'b0;
              r_state  <= ST_LDAC;
`else
              r_done   <= 1'b1;
              r_state  <= ST_IDLE;
`endif
            end
          end
        end
`ifdef DAC_LDAC_EN
        ST_LDAC: begin
          if (w_tick) begin
            r_ldac_n <= 1'b1;
            r_done   <= 1'b1;
            r_state  <= ST_IDLE;
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_done   = r_done;
  assign o_idle   = (r_state == ST_IDLE);
  assign o_cs_n   = r_cs_n;
  assign o_sck    = r_sck;
  assign o_mosi   = r_mosi;
`ifdef DAC_LDAC_EN
  assign o_ldac_n = r_ldac_n;
`endif

endmodule

// File: rtl/dac_write_arbiter.sv
// Round-robin arbiter granting NREQ writers access to one SPI DAC.
// Ports: clk, rst, req, req_data, req_cfg in; gnt, done, busy, cs_n,
// sck, mosi out (+ ldac_n when DAC_LDAC_EN is defined).
module dac_write_arbiter
  import dac_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int SCK_DIV = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DATA_W-1:0]  req_data,
  input  logic [NREQ*CFG_W-1:0]   req_cfg,
  output logic [NREQ-1:0]         gnt,
  output logic                    done,
  output logic                    busy,
`ifdef DAC_LDAC_EN
  output logic                    ldac_n,
`endif
  output logic                    cs_n,
  output logic                    sck,
  output logic                    mosi
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   r_ptr;
  logic [NREQ-1:0] r_gnt;
  logic            r_busy;

  logic [PW-1:0]      w_win;
  logic               w_any;
  logic               w_idle;
  logic               w_start;
  logic [FRAME_W-1:0] w_frame;

  // Scan from the pointer, wrapping, first asserted request wins
  always_comb begin
    int          j;
    logic [PW-1:0] idx;
    w_win = '0;
    w_any = 1'b0;
    j     = 0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(r_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      idx = PW'(j);
      if (!w_any && req[idx]) begin
        w_any = 1'b1;
        w_win = idx;
      end
    end
  end

  assign w_start = w_idle & w_any;
  assign w_frame = mk_frame(req_cfg[w_win*CFG_W +: CFG_W],
                            req_data[w_win*DATA_W +: DATA_W]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr  <= '0;
      r_gnt  <= '0;
      r_busy <= 1'b0;
    end else begin
      r_gnt <= '0;
      if (w_start) begin
        r_gnt  <= NREQ'(1) << w_win;
        r_busy <= 1'b1;
        r_ptr  <= (w_win == PW'(NREQ - 1)) ? '0 : w_win + 1'b1;
      end else if (done) begin
        r_busy <= 1'b0;
      end
    end
  end

  spi_frame_tx #(
    .SCK_DIV (SCK_DIV)
  ) u_tx (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start),
    .i_frame  (w_frame),
    .o_done   (done),
    .o_idle   (w_idle),
`ifdef DAC_LDAC_EN
    .o_ldac_n (ldac_n),
`endif
    .o_cs_n   (cs_n),
    .o_sck    (sck),
    .o_mosi   (mosi)
  );

  assign gnt  = r_gnt;
  assign busy = r_busy;

endmodule

// File: doc/dac_write_arbiter.md
DAC_WRITE_ARBITER -- requirements
Module: dac_write_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NREQ, 4, number of requesters (2..8).
- SCK_DIV, 256, clk cycles per SCK half-period tick (>=2).
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester write request, level.
- req_data  in  NREQ*12  per-requester 12-bit DAC code, requester i at [12i+11:12i].
- req_cfg  in  NREQ*4  per-requester frame header {A/B, BUF, GA_n, SHDN_n}, requester i at [4i+3:4i].
- gnt  out  NREQ  one-hot, one-cycle grant pulse.
- done  out  1  one-cycle pulse when a frame completes.
- busy  out  1  high from grant cycle until done inclusive.
- cs_n  out  1  DAC chip select, active low.
- sck  out  1  SPI clock, idle low.
- mosi  out  1  serial data, MSB first.

Function
REQ-003 States SHALL be IDLE, SHIFT, GAP (plus LDAC when configured).
REQ-004 In IDLE with any req bit high at edge N, the block SHALL assert exactly one gnt bit, latch {req_cfg, req_data} of the winner into a 16-bit frame, drive cs_n low, mosi to frame bit 15, and enter SHIFT, all registered at edge N+1.
REQ-005 Arbitration SHALL be round-robin: priority starts at (last granted index + 1) mod NREQ; after reset, requester 0 has top priority.
REQ-006 Requests arriving while busy SHALL wait; a req dropped before its gnt SHALL never be granted; data SHALL be sampled only on the gnt cycle.
REQ-007 A tick SHALL occur every SCK_DIV clk cycles, counted from entry into SHIFT; the divider SHALL be held at 0 in IDLE.
REQ-008 In SHIFT, each tick SHALL toggle sck.
- A rising toggle leaves mosi unchanged (DAC samples here).
- A falling toggle presents the next bit on mosi.
- After the 16th falling toggle (tick 32), mosi SHALL go 0 and the state SHALL become GAP.
REQ-009 cs_n SHALL rise at tick 33, held high in GAP for one tick; at tick 34, done SHALL pulse, busy SHALL fall, and the state SHALL return to IDLE.
REQ-010 Frame period (grant to done) SHALL be 34*SCK_DIV cycles; the next grant SHALL come no earlier than the cycle after done.
REQ-011 Simultaneous requests SHALL be served in round-robin order back-to-back with no lost requests while held.

Reset
REQ-012 On rst, at the next edge: cs_n=1, sck=0, mosi=0, gnt=0, done=0, busy=0, state=IDLE, divider=0, RR pointer selects requester 0.
REQ-013 Reset mid-frame SHALL abort the frame without a done pulse; a partial frame is discarded by the DAC via cs_n rising.

Configuration
REQ-014 With DAC_LDAC_EN defined:
- Port ldac_n (out, 1, DAC latch, active low, reset 1) SHALL exist.
- After GAP, state LDAC SHALL drive ldac_n low for one tick.
- done SHALL then pulse at tick 35, giving a period of 35*SCK_DIV.
REQ-015 Without DAC_LDAC_EN, port ldac_n and state LDAC SHALL be absent, and timing SHALL be per REQ-009/010.

Structure
REQ-016 Shared package dac_arb_pkg SHALL hold: state encodings, FRAME_W=16, DATA_W=12, CFG_W=4, and cfg bit positions (A/B=3, BUF=2, GA_n=1, SHDN_n=0).
REQ-017 Serialization (divider, sck/mosi/cs_n, SHIFT/GAP sequencing) SHALL live in sub-module spi_frame_tx with start/frame/done handshake; arbitration stays in the top.

Verification (NREQ=4, SCK_DIV=4)
REQ-018 Single req[2]=1, data 0x3E8, cfg 0x7 -> gnt=0100 one cycle later; mosi shifts 0x73E8 MSB-first on 16 sck rising edges; done 136 cycles after gnt.
REQ-019 req=1111 held -> grant order 0,1,2,3,0; each grant exactly one cycle after the previous done.
REQ-020 req[1] pulsed for 1 cycle while a frame is busy -> never granted; no extra frame.
REQ-021 rst asserted at tick 10 of a frame -> next edge cs_n=1, sck=0, mosi=0, busy=0; no done; a following req[0] is granted normally.
REQ-022 Data 0x000 and 0xFFF with cfg 0x3 -> frames 0x3000 and 0x3FFF bit-exact; cs_n high for >=SCK_DIV cycles between frames.
REQ-023 With DAC_LDAC_EN -> ldac_n low for 4 cycles after cs_n rises; done at 140 cycles after gnt.
